// File: rtl/seg_execute_muldiv_ctrl.sv
// Iterative unsigned multiply/divide unit for the execute stage: one shift-add or
// restoring-division step per cycle, with HI/LO result registers and MTHI/MTLO moves.
module seg_execute_muldiv_ctrl #(
    parameter int NB_DATA = 32,
    parameter int NB_CNT  = 5,
    parameter int NB_MDOP = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_MDOP-1:0] i_mdop,
    input  logic [NB_DATA-1:0] i_rs,
    input  logic [NB_DATA-1:0] i_rt,
    input  logic               i_flush,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_div_by_zero,
    output logic [NB_DATA-1:0] o_hi,
    output logic [NB_DATA-1:0] o_lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic [NB_MDOP-1:0] OP_MULTU = NB_MDOP'(0);
    localparam logic [NB_MDOP-1:0] OP_DIVU  = NB_MDOP'(1);
    localparam logic [NB_MDOP-1:0] OP_MTHI  = NB_MDOP'(2);
    localparam logic [NB_MDOP-1:0] OP_MTLO  = NB_MDOP'(3);
    localparam logic [NB_CNT-1:0]  CNT_LAST = {NB_CNT{1'b1}};

    state_t              state_r, state_s;
    logic [NB_CNT-1:0]   cnt_r, cnt_s;
    // acc holds the running product high half / partial remainder,
    // shf holds the multiplier-then-product-low / dividend-then-quotient.
    logic [NB_DATA-1:0]  acc_r, acc_s;
    logic [NB_DATA-1:0]  shf_r, shf_s;
    logic [NB_DATA-1:0]  opnd_r, opnd_s;
    logic [NB_DATA-1:0]  hi_r, hi_s;
    logic [NB_DATA-1:0]  lo_r, lo_s;
    logic                busy_r, done_r, dz_r, dz_s;

    logic [NB_DATA:0]    mul_sum_s;
    logic [NB_DATA-1:0]  mul_acc_s, mul_shf_s;
    logic [NB_DATA:0]    div_rem_sh_s, div_diff_s;
    logic [NB_DATA-1:0]  div_acc_s, div_shf_s;

    // One datapath step for each algorithm, evaluated from the current registers.
    always_comb begin
        mul_sum_s    = {1'b0, acc_r} + (shf_r[0] ? {1'b0, opnd_r} : {(NB_DATA+1){1'b0}});
        mul_acc_s    = mul_sum_s[NB_DATA:1];
        mul_shf_s    = {mul_sum_s[0], shf_r[NB_DATA-1:1]};
        div_rem_sh_s = {acc_r, shf_r[NB_DATA-1]};
        div_diff_s   = div_rem_sh_s - {1'b0, opnd_r};
        // A borrow out of the top bit means the divisor did not fit: restore.
        if (div_diff_s[NB_DATA]) begin
            div_acc_s = div_rem_sh_s[NB_DATA-1:0];
            div_shf_s = {shf_r[NB_DATA-2:0], 1'b0};
        end else begin
            div_acc_s = div_diff_s[NB_DATA-1:0];
            div_shf_s = {shf_r[NB_DATA-2:0], 1'b1};
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        acc_s   = acc_r;
        shf_s   = shf_r;
        opnd_s  = opnd_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        dz_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                state_s = ST_IDLE;
                // A flush in the same cycle as a start cancels the request outright.
                if (i_start && !i_flush) begin
                    case (i_mdop)
                        OP_MULTU: begin
                            state_s = ST_MUL;
                            cnt_s   = {NB_CNT{1'b0}};
                            opnd_s  = i_rs;
                            shf_s   = i_rt;
                            acc_s   = {NB_DATA{1'b0}};
                        end
                        OP_DIVU: begin
                            if (i_rt == {NB_DATA{1'b0}}) begin
                                state_s = ST_DONE;
                                hi_s    = i_rs;
                                lo_s    = {NB_DATA{1'b1}};
                                dz_s    = 1'b1;
                            end else begin
                                state_s = ST_DIV;
                                cnt_s   = {NB_CNT{1'b0}};
                                opnd_s  = i_rt;
                                shf_s   = i_rs;
                                acc_s   = {NB_DATA{1'b0}};
                            end
                        end
                        OP_MTHI: hi_s    = i_rs;
                        OP_MTLO: lo_s    = i_rs;
                        default: state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (i_flush) begin
                    state_s = ST_IDLE;
                end else begin
                    acc_s = mul_acc_s;
                    shf_s = mul_shf_s;
                    cnt_s = cnt_r + NB_CNT'(1);
                    // The counter wrapping from all-ones marks the final iteration.
                    if (cnt_r == CNT_LAST) begin
                        state_s = ST_DONE;
                        hi_s    = mul_acc_s;
                        lo_s    = mul_shf_s;
                    end else begin
                        state_s = ST_MUL;
                    end
                end
            end
            ST_DIV: begin
                if (i_flush) begin
                    state_s = ST_IDLE;
                end else begin
                    acc_s = div_acc_s;
                    shf_s = div_shf_s;
                    cnt_s = cnt_r + NB_CNT'(1);
                    if (cnt_r == CNT_LAST) begin
                        state_s = ST_DONE;
                        hi_s    = div_acc_s;
                        lo_s    = div_shf_s;
                    end else begin
                        state_s = ST_DIV;
                    end
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, datapath and output registers; status flags follow the next state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {NB_CNT{1'b0}};
            acc_r   <= {NB_DATA{1'b0}};
            shf_r   <= {NB_DATA{1'b0}};
            opnd_r  <= {NB_DATA{1'b0}};
            hi_r    <= {NB_DATA{1'b0}};
            lo_r    <= {NB_DATA{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dz_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            acc_r   <= acc_s;
            shf_r   <= shf_s;
            opnd_r  <= opnd_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            busy_r  <= (state_s == ST_MUL) || (state_s == ST_DIV);
            done_r  <= (state_s == ST_DONE);
            dz_r    <= dz_s;
        end
    end

    assign o_busy        = busy_r;
    assign o_done        = done_r;
    assign o_div_by_zero = dz_r;
    assign o_hi          = hi_r;
    assign o_lo          = lo_r;

endmodule

// File: tb/tb_seg_execute_muldiv_ctrl.sv
// Directed bench for seg_execute_muldiv_ctrl: an arithmetic reference model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_seg_execute_muldiv_ctrl;

    localparam int NB_DATA = 32;
    localparam int NB_CNT  = 5;
    localparam int NB_MDOP = 2;

    logic        clk = 1'b0;
    logic        i_reset, i_start, i_flush;
    logic [1:0]  i_mdop;
    logic [31:0] i_rs, i_rt;
    logic        o_busy, o_done, o_div_by_zero;
    logic [31:0] o_hi, o_lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_execute_muldiv_ctrl #(.NB_DATA(NB_DATA), .NB_CNT(NB_CNT), .NB_MDOP(NB_MDOP)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_mdop(i_mdop),
        .i_rs(i_rs), .i_rt(i_rt), .i_flush(i_flush), .o_busy(o_busy),
        .o_done(o_done), .o_div_by_zero(o_div_by_zero), .o_hi(o_hi), .o_lo(o_lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles of work remaining plus the pending arithmetic result.
    int          m_left = 0;
    logic [31:0] m_hi = 32'h0, m_lo = 32'h0, m_phi = 32'h0, m_plo = 32'h0;
    logic        m_done = 1'b0, m_dz = 1'b0;
    logic [63:0] m_prod;

    always @(posedge clk) begin
        if (i_reset) begin
            m_left = 0; m_hi = 32'h0; m_lo = 32'h0; m_done = 1'b0; m_dz = 1'b0;
        end else if (m_left > 0) begin
            if (i_flush) begin
                m_left = 0;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_hi = m_phi; m_lo = m_plo; m_done = 1'b1;
                end
            end
        end else begin
            m_done = 1'b0; m_dz = 1'b0;
            if (i_start && !i_flush) begin
                case (i_mdop)
                    2'b00: begin
                        m_prod = {32'h0, i_rs} * {32'h0, i_rt};
                        m_phi = m_prod[63:32]; m_plo = m_prod[31:0]; m_left = NB_DATA;
                    end
                    2'b01: begin
                        if (i_rt == 32'h0) begin
                            m_hi = i_rs; m_lo = 32'hFFFF_FFFF; m_done = 1'b1; m_dz = 1'b1;
                        end else begin
                            m_plo = i_rs / i_rt; m_phi = i_rs % i_rt; m_left = NB_DATA;
                        end
                    end
                    2'b10: m_hi = i_rs;
                    default: m_lo = i_rs;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("model_busy", o_busy, m_left > 0);
        chk("model_done", o_done, m_done);
        chk("model_dz", o_div_by_zero, m_dz);
        chk("model_hi", o_hi, m_hi);
        chk("model_lo", o_lo, m_lo);
    end

    // Present a one-cycle request, then scramble the operands.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        i_start = 1'b1; i_mdop = op; i_rs = a; i_rt = b;
        @(negedge clk);
        i_start = 1'b0; i_rs = ~a; i_rt = b + 32'd1;
    endtask

    task automatic expect_busy_run(input string name);
        for (int i = 0; i < NB_DATA; i++) begin
            chk(name, o_busy, 1'b1);
            @(negedge clk);
        end
    endtask

    logic [1:0]  t_op [5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    logic [31:0] t_a  [5] = '{32'h0001_0000, 32'd5, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h8000_0000};
    logic [31:0] t_b  [5] = '{32'h0001_0000, 32'd7, 32'd1, 32'h10, 32'd2};
    logic [31:0] t_hi [5] = '{32'h1, 32'd5, 32'h0, 32'hF, 32'h1};
    logic [31:0] t_lo [5] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0DEA_DBEE, 32'h0};

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_flush = 1'b0; i_mdop = 2'b00; i_rs = 32'h0; i_rt = 32'h0;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        chk("reset_hi", o_hi, 32'h0);
        chk("reset_lo", o_lo, 32'h0);
        chk("reset_busy", o_busy, 1'b0);

        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        expect_busy_run("mul_max_busy");
        chk("mul_max_done", o_done, 1'b1);
        chk("mul_max_hi", o_hi, 32'hFFFF_FFFE);
        chk("mul_max_lo", o_lo, 32'h0000_0001);
        @(negedge clk);
        chk("mul_max_done_drop", o_done, 1'b0);

        issue(2'b01, 32'd100, 32'd7);
        expect_busy_run("div_busy");
        chk("div_done", o_done, 1'b1);
        chk("div_lo", o_lo, 32'd14);
        chk("div_hi", o_hi, 32'd2);
        chk("div_dz", o_div_by_zero, 1'b0);

        issue(2'b01, 32'h1234, 32'h0);
        chk("dz_busy", o_busy, 1'b0);
        chk("dz_done", o_done, 1'b1);
        chk("dz_flag", o_div_by_zero, 1'b1);
        chk("dz_hi", o_hi, 32'h1234);
        chk("dz_lo", o_lo, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("dz_flag_drop", o_div_by_zero, 1'b0);

        issue(2'b00, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        chk("flush_busy", o_busy, 1'b0);
        chk("flush_hi", o_hi, 32'h1234);
        chk("flush_lo", o_lo, 32'hFFFF_FFFF);
        repeat (30) @(negedge clk);
        chk("flush_no_done", o_done, 1'b0);

        i_start = 1'b1; i_mdop = 2'b10; i_rs = 32'hA5A5_A5A5;
        @(negedge clk);
        chk("mthi_hi", o_hi, 32'hA5A5_A5A5);
        i_mdop = 2'b11; i_rs = 32'h5A5A_5A5A;
        @(negedge clk);
        i_start = 1'b0;
        chk("mtlo_lo", o_lo, 32'h5A5A_5A5A);
        chk("mtlo_hi_kept", o_hi, 32'hA5A5_A5A5);
        chk("mtlo_busy", o_busy, 1'b0);

        i_start = 1'b1; i_flush = 1'b1; i_mdop = 2'b00; i_rs = 32'd9; i_rt = 32'd9;
        @(negedge clk);
        i_start = 1'b0; i_flush = 1'b0;
        chk("flush_start_busy", o_busy, 1'b0);
        chk("flush_start_lo", o_lo, 32'h5A5A_5A5A);

        // Held start: the new operands must wait for DONE before being accepted.
        i_start = 1'b1; i_mdop = 2'b00; i_rs = 32'd3; i_rt = 32'd4;
        @(negedge clk);
        i_rs = 32'd7; i_rt = 32'd9;
        expect_busy_run("held_busy");
        chk("held_done", o_done, 1'b1);
        chk("held_lo", o_lo, 32'd12);
        @(negedge clk);
        i_start = 1'b0;
        chk("held_reaccept_busy", o_busy, 1'b1);
        repeat (NB_DATA) @(negedge clk);
        chk("held_second_lo", o_lo, 32'd63);
        chk("held_second_hi", o_hi, 32'd0);

        for (int k = 0; k < 5; k++) begin
            issue(t_op[k], t_a[k], t_b[k]);
            repeat (NB_DATA) @(negedge clk);
            chk("table_hi", o_hi, t_hi[k]);
            chk("table_lo", o_lo, t_lo[k]);
        end

        issue(2'b01, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        chk("rst_mid_busy", o_busy, 1'b0);
        chk("rst_mid_hi", o_hi, 32'h0);
        chk("rst_mid_lo", o_lo, 32'h0);
        repeat (40) @(negedge clk);
        chk("rst_mid_no_done", o_done, 1'b0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_execute_muldiv_ctrl.md
SEG_EXECUTE_MULDIV_CTRL -- requirements
Module: seg_execute_muldiv_ctrl

Interface
REQ-001 SHALL have parameter NB_DATA, default 32: operand and HI/LO width.
REQ-002 SHALL have parameter NB_CNT, default 5: iteration-counter width, with 2^NB_CNT = NB_DATA.
REQ-003 SHALL have parameter NB_MDOP, default 2: operation-code width.
REQ-004 SHALL have one clock and a synchronous, active-high reset: the clock and reset ports SHALL be named as the codebase names them.
REQ-005 SHALL have these ports, one per line (name, direction, width, meaning):
  i_clk  in  1  clock, rising edge.
  i_reset  in  1  synchronous active-high reset.
  i_start  in  1  request from the execute stage.
  i_mdop  in  NB_MDOP  operation: 00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO.
  i_rs  in  NB_DATA  operand A (multiplicand, dividend, or move source).
  i_rt  in  NB_DATA  operand B (multiplier or divisor).
  i_flush  in  1  cancel the in-flight operation.
  o_busy  out  1  pipeline stall request.
  o_done  out  1  one-cycle completion pulse.
  o_div_by_zero  out  1  DIVU issued with i_rt = 0.
  o_hi  out  NB_DATA  HI register.
  o_lo  out  NB_DATA  LO register.

Function
REQ-006 SHALL implement FSM states IDLE, MUL, DIV and DONE, with all outputs registered.
REQ-007 SHALL accept i_start only in IDLE or DONE, and SHALL ignore it in MUL and DIV.
REQ-008 On accepted MULTU, the next state SHALL be MUL with the counter cleared, the multiplicand latched and the accumulator cleared.
REQ-009 On accepted DIVU with i_rt != 0, the next state SHALL be DIV with the counter cleared and the operands latched.
REQ-010 On accepted DIVU with i_rt = 0, the next state SHALL be DONE, with o_hi = i_rs, o_lo = all ones and o_div_by_zero = 1.
REQ-011 On accepted MTHI or MTLO, o_hi or o_lo respectively SHALL take i_rs at the same edge, the state SHALL stay or return to IDLE, o_done SHALL remain 0 and o_busy SHALL remain 0.
REQ-012 MUL SHALL perform one unsigned shift-add iteration per cycle, exactly NB_DATA iterations.
REQ-013 The multiply result SHALL be the full 2*NB_DATA-bit product, with o_hi the upper half and o_lo the lower half.
REQ-014 DIV SHALL perform one restoring-division iteration per cycle, exactly NB_DATA iterations.
REQ-015 The divide result SHALL place the quotient in o_lo and the remainder in o_hi.
REQ-016 Timing: with start sampled at edge n, o_busy SHALL be 1 after edges n through n+NB_DATA-1, i.e. NB_DATA cycles.
REQ-017 After edge n+NB_DATA, the state SHALL be DONE, o_hi and o_lo SHALL hold the new result and o_done SHALL be 1 for exactly one cycle.
REQ-018 o_busy SHALL be 0 in IDLE and DONE, and 1 only in MUL and DIV.
REQ-019 o_done SHALL be 1 only in DONE.
REQ-020 o_div_by_zero SHALL be 1 only in a DONE state entered through REQ-010.
REQ-021 DONE SHALL last one cycle, then go to IDLE, unless a new start is accepted in that cycle (REQ-007).
REQ-022 o_hi and o_lo SHALL change only on completion (entry to DONE) or on MTHI/MTLO, and SHALL hold their values otherwise.
REQ-023 i_flush in MUL or DIV SHALL force IDLE at the next edge, leave o_hi and o_lo unchanged, and produce no o_done pulse.
REQ-024 i_flush asserted together with i_start SHALL win: nothing SHALL be accepted and no register SHALL change.
REQ-025 i_flush in IDLE or DONE SHALL have no effect other than REQ-024.
REQ-026 Counter wrap SHALL be the completion condition: the last iteration SHALL occur at count 2^NB_CNT-1, and no extra iteration SHALL be performed.
REQ-027 Operand inputs SHALL be sampled only at the accepting edge; changes to them during MUL or DIV SHALL have no effect.

Reset
REQ-028 With i_reset = 1 at an edge: state SHALL be IDLE, counter 0, o_hi = 0, o_lo = 0, o_busy = 0, o_done = 0 and o_div_by_zero = 0.
REQ-029 Reset SHALL take priority over i_start and i_flush.
REQ-030 Reset during MUL or DIV SHALL abort the operation, and no o_done pulse SHALL follow.

Verification
REQ-031 MULTU with rs = 0xFFFFFFFF, rt = 0xFFFFFFFF -> o_busy high for 32 cycles; o_done pulse at cycle 32; o_hi = 0xFFFFFFFE; o_lo = 0x00000001.
REQ-032 DIVU with rs = 100, rt = 7 -> 32 busy cycles; o_lo = 14; o_hi = 2; o_div_by_zero = 0.
REQ-033 DIVU with rs = 0x1234, rt = 0 -> o_busy never high; o_done and o_div_by_zero high on the next cycle; o_hi = 0x1234; o_lo = 0xFFFFFFFF.
REQ-034 MULTU 5*6, with i_flush at busy cycle 10 -> IDLE next cycle; o_hi and o_lo keep their previous values; no o_done pulse.
REQ-035 MTHI with 0xA5A5A5A5, then MTLO with 0x5A5A5A5A on the next cycle -> o_hi and o_lo updated one edge after each; o_busy = 0 and o_done = 0 throughout.
REQ-036 Start held high during MUL with different operands, and reset asserted mid-DIV -> the held start is ignored until DONE; the reset returns every output to 0 with no o_done pulse.
